// File: rtl/i2c_pkg.sv
// Shared I2C definitions: the target FSM state set, byte/address geometry,
// and the bus-level constants for the R/W bit and the ACK/NACK bit.
// i2c_top also uses the ACK constants from this package.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 3;

    // Value of the bit counter on the last bit of a byte.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    localparam logic RW_READ = 1'b1;
    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronises scl/sda into the clk domain and derives
// single-cycle bus events from the last two synchroniser stages.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset (flops reset to 1)
//   scl, sda   raw bus levels
//   scl_rise   synchronised scl rising edge (one clk)
//   scl_fall   synchronised scl falling edge (one clk)
//   start_det  sda fell while scl held high (one clk)
//   stop_det   sda rose while scl held high (one clk)
//   sda_bit    synchronised sda level, used when sampling data bits
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    // Bit 0 is the newest stage, bit SYNC_STAGES-1 the oldest.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;

    logic scl_cur, scl_prev;
    logic sda_cur, sda_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    always_comb begin
        scl_cur  = scl_sync[SYNC_STAGES-2];
        scl_prev = scl_sync[SYNC_STAGES-1];
        sda_cur  = sda_sync[SYNC_STAGES-2];
        sda_prev = sda_sync[SYNC_STAGES-1];

        scl_rise = scl_cur & ~scl_prev;
        scl_fall = ~scl_cur & scl_prev;
        // scl must be high in both stages so that an sda change racing an
        // scl edge is never mistaken for a bus condition.
        start_det = scl_cur & scl_prev & sda_prev & ~sda_cur;
        stop_det  = scl_cur & scl_prev & ~sda_prev & sda_cur;
        sda_bit   = sda_cur;
    end

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target. Oversamples the bus, recognises START/STOP,
// matches SLAVE_ADDR, ACKs address and write bytes, and shifts out bytes
// supplied by local logic on reads. No clock stretching; sda is open-drain.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   scl        bus clock from the master
//   sda        bus data, driven 0 or released (high-Z), never driven 1
//   tx_data    byte returned on a read, captured in the tx_load cycle
//   tx_load    one-clk pulse in the cycle tx_data is captured
//   rx_data    last byte written by the master
//   rx_valid   one-clk pulse when rx_data is updated
//   busy       high from the address ACK until STOP, repeated START or NACK
//   rd_mode    R/W bit of the current matched transfer (1 = read)
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h10,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_load,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              rd_mode
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, cnt_nx;
    logic [BYTE_W-1:0] shreg, shreg_nx, shifted;
    logic [BYTE_W-1:0] rx_data_nx;
    // In ADDR_ACK/WR_ACK: 0 = waiting for the fall that starts the ACK,
    // 1 = ACK being driven. In RD_ACK: 1 = master ACKed, waiting for the fall.
    logic              phase, phase_nx;
    logic              busy_nx, rd_mode_nx, rx_valid_nx;
    logic              load_evt;
    logic              sda_drive;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_bit  (sda_bit)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            phase    <= 1'b0;
            busy     <= 1'b0;
            rd_mode  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= cnt_nx;
            shreg    <= shreg_nx;
            phase    <= phase_nx;
            busy     <= busy_nx;
            rd_mode  <= rd_mode_nx;
            rx_data  <= rx_data_nx;
            rx_valid <= rx_valid_nx;
        end
    end

    // Next-state logic. Bus conditions override whatever the state is doing.
    always_comb begin
        state_nx    = state;
        cnt_nx      = bit_cnt;
        shreg_nx    = shreg;
        phase_nx    = phase;
        busy_nx     = busy;
        rd_mode_nx  = rd_mode;
        rx_data_nx  = rx_data;
        rx_valid_nx = 1'b0;
        load_evt    = 1'b0;
        shifted     = {shreg[BYTE_W-2:0], sda_bit};

        if (start_det) begin
            state_nx = ADDR;
            cnt_nx   = '0;
            phase_nx = 1'b0;
            busy_nx  = 1'b0;
        end else if (stop_det) begin
            state_nx = IDLE;
            phase_nx = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                IDLE, IGNORE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shreg_nx = shifted;
                        cnt_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            // shreg holds the 7 address bits; sda_bit is R/W.
                            if (shreg[ADDR_W-1:0] == SLAVE_ADDR) begin
                                state_nx   = ADDR_ACK;
                                rd_mode_nx = sda_bit;
                                phase_nx   = 1'b0;
                            end else begin
                                state_nx = IGNORE;
                            end
                        end
                    end
                end

                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            phase_nx = 1'b1;
                            busy_nx  = 1'b1;
                        end else begin
                            phase_nx = 1'b0;
                            cnt_nx   = '0;
                            if (state == ADDR_ACK && rd_mode == RW_READ) begin
                                load_evt = 1'b1;
                            end else begin
                                state_nx = WR_DATA;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nx = shifted;
                        cnt_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_nx  = shifted;
                            rx_valid_nx = 1'b1;
                            state_nx    = WR_ACK;
                            phase_nx    = 1'b0;
                        end
                    end
                end

                RD_DATA: begin
                    // shreg[MSB] is the bit on the bus; each fall shifts the
                    // next one up, and the fall after bit0 releases the line.
                    if (scl_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            cnt_nx   = '0;
                            state_nx = RD_ACK;
                            phase_nx = 1'b0;
                        end else begin
                            cnt_nx   = bit_cnt + 1'b1;
                            shreg_nx = {shreg[BYTE_W-2:0], 1'b0};
                        end
                    end
                end

                RD_ACK: begin
                    if (!phase) begin
                        if (scl_rise) begin
                            if (sda_bit == ACK) begin
                                phase_nx = 1'b1;
                            end else begin
                                state_nx = IGNORE;
                                busy_nx  = 1'b0;
                            end
                        end
                    end else if (scl_fall) begin
                        phase_nx = 1'b0;
                        load_evt = 1'b1;
                    end
                end

                default: state_nx = IDLE;
            endcase

            if (load_evt) begin
                shreg_nx = tx_data;
                cnt_nx   = '0;
                state_nx = RD_DATA;
            end
        end
    end

    // Outputs. A bus condition releases sda in the same clk it is seen.
    always_comb begin
        tx_load   = load_evt;
        sda_drive = 1'b0;
        if (!start_det && !stop_det) begin
            case (state)
                ADDR_ACK, WR_ACK: sda_drive = phase;
                RD_DATA:          sda_drive = ~shreg[BYTE_W-1];
                default:          sda_drive = 1'b0;
            endcase
        end
    end

    assign sda = sda_drive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int unsigned Q       = 8;       // clk cycles per scl phase
    localparam logic [6:0]  MY_ADDR = 7'h10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda;                         // master: 1 = release, 0 = pull low
    logic [7:0] tx_data;
    logic       tx_load, rx_valid, busy, rd_mode;
    logic [7:0] rx_data;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_slave #(
        .SLAVE_ADDR (MY_ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda_bus),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .rd_mode (rd_mode)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tx_load_cnt = 0, rx_cnt = 0, slave_low_cnt = 0, busy_hi_cnt = 0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the target answers only its own address; once matched
    // every written byte is ACKed and delivered, every read byte comes from
    // the local byte stream. Unmatched transfers see a released (1) bus.
    function automatic logic model_ack(input logic [6:0] a);
        return (a == MY_ADDR) ? ACK : NACK;
    endfunction

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (tx_load) tx_load_cnt++;
        if (busy) busy_hi_cnt++;
        if (m_sda && sda_bus === 1'b0) slave_low_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_valid with %0h, expected none", rx_data);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
    end

    // Local-logic byte source: advance after each capture.
    initial forever begin
        @(negedge clk);
        if (tx_load) begin
            @(posedge clk);
            #1;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-banged master.
    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        m_sda = 1'b0; tick(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(2); m_sda = 1'b0; tick(Q - 2);
        scl = 1'b1;   tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        tick(2); m_sda = b; tick(Q - 2);
        scl = 1'b1; tick(Q);
        scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(2); m_sda = 1'b1; tick(Q - 2);
        scl = 1'b1; tick(Q / 2);
        b = sda_bus; tick(Q / 2);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(mack);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d [3], input int unsigned n);
        logic ack;
        logic hit;
        hit = (a == MY_ADDR);
        bus_start();
        write_byte({a, 1'b0}, ack);
        chk("addr_ack_w", ack, model_ack(a));
        chk("busy_after_addr_w", busy, hit);
        for (int unsigned i = 0; i < n; i++) begin
            if (hit) exp_rx.push_back(d[i]);
            write_byte(d[i], ack);
            chk("data_ack", ack, hit ? ACK : NACK);
        end
        if (hit) chk("rd_mode_w", rd_mode, 1'b0);
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] d [3], input int unsigned n);
        logic ack;
        logic hit;
        logic [7:0] got;
        int unsigned loads0;
        hit = (a == MY_ADDR);
        tx_q.delete();
        for (int unsigned i = 0; i < n; i++) tx_q.push_back(d[i]);
        tx_data = tx_q[0];
        loads0 = tx_load_cnt;
        bus_start();
        write_byte({a, RW_READ}, ack);
        chk("addr_ack_r", ack, model_ack(a));
        for (int unsigned i = 0; i < n; i++) begin
            read_byte(got, (i == n - 1) ? NACK : ACK);
            chk("rd_byte", got, hit ? d[i] : 8'hFF);
        end
        chk("tx_load_count", tx_load_cnt - loads0, hit ? n : 0);
        chk("busy_after_nack", busy, 1'b0);
        if (hit) begin
            chk("rd_mode_r", rd_mode, 1'b1);
            chk("state_ignore", dut.state, IGNORE);
        end
    endtask

    task automatic stop_and_check_busy();
        fork
            bus_stop();
            begin
                logic seen;
                seen = 1'b0;
                for (int unsigned k = 0; k < 60 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.u_bus.stop_det) seen = 1'b1;
                end
                chk("stop_detected", seen, 1'b1);
                if (seen) begin
                    chk("busy_at_stop", busy, 1'b1);
                    @(negedge clk);
                    chk("busy_after_stop", busy, 1'b0);
                end
            end
        join
    endtask

    initial begin
        logic [7:0] d [3];
        logic ack;
        logic [7:0] got;
        int unsigned rx0, low0, busy0;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_load", tx_load, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_mode", rd_mode, 1'b0);
        chk("rst_sda", sda_bus, 1'b1);

        // Single write byte.
        rx0 = rx_cnt;
        d = '{8'hA5, 8'h00, 8'h00};
        do_write(MY_ADDR, d, 1);
        stop_and_check_busy();
        chk("wr_rx_data", rx_data, 8'hA5);
        chk("wr_rx_count", rx_cnt - rx0, 1);

        // Single read byte with NACK.
        d = '{8'h3C, 8'h00, 8'h00};
        do_read(MY_ADDR, d, 1);
        chk("sda_released_after_nack", sda_bus, 1'b1);
        bus_stop();

        // Wrong address.
        rx0 = rx_cnt; low0 = slave_low_cnt; busy0 = busy_hi_cnt;
        d = '{8'h5E, 8'h00, 8'h00};
        do_write(7'h11, d, 1);
        bus_stop();
        chk("mismatch_no_drive", slave_low_cnt - low0, 0);
        chk("mismatch_no_busy", busy_hi_cnt - busy0, 0);
        chk("mismatch_no_rx", rx_cnt - rx0, 0);

        // Three write bytes in one transfer.
        rx0 = rx_cnt;
        d = '{8'h12, 8'h34, 8'h56};
        do_write(MY_ADDR, d, 3);
        bus_stop();
        chk("multi_rx_count", rx_cnt - rx0, 3);

        // Two read bytes, tx_data advanced between loads.
        d = '{8'hC3, 8'h5A, 8'h00};
        do_read(MY_ADDR, d, 2);
        bus_stop();

        // Repeated START after 4 data bits, then a read.
        rx0 = rx_cnt;
        bus_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        chk("rs_addr_ack", ack, ACK);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        d = '{8'h96, 8'h00, 8'h00};
        do_read(MY_ADDR, d, 1);
        bus_stop();
        chk("rs_no_rx", rx_cnt - rx0, 0);

        // Reset pulse while the address ACK is being driven.
        rx0 = rx_cnt;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit((i == 0) ? 1'b0 : MY_ADDR[i - 1]);
        m_sda = 1'b1;
        tick(4);
        chk("ack_driven_before_rst", sda_bus, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("sda_released_after_rst", sda_bus, 1'b1);
        chk("busy_after_rst", busy, 1'b0);
        chk("rx_data_after_rst", rx_data, 8'h00);
        tick(Q - 6);
        scl = 1'b1; tick(Q);
        scl = 1'b0;
        write_byte(8'h77, ack);
        chk("no_ack_after_rst", ack, NACK);
        bus_stop();
        chk("no_rx_after_rst", rx_cnt - rx0, 0);
        d = '{8'h9E, 8'h00, 8'h00};
        do_write(MY_ADDR, d, 1);
        bus_stop();

        // Randomised transfers against the model.
        for (int unsigned t = 0; t < 8; t++) begin
            logic [6:0] a;
            int unsigned n;
            if ($urandom_range(0, 1) == 1) begin
                a = MY_ADDR;
            end else begin
                a = 7'($urandom_range(0, 127));
                if (a == MY_ADDR) a = a ^ 7'h01;
            end
            n = $urandom_range(1, 3);
            for (int unsigned i = 0; i < 3; i++) d[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) do_read(a, d, n);
            else do_write(a, d, n);
            bus_stop();
        end

        tick(20);
        chk("rx_queue_drained", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
